alu_issue_ctrl: RTL and testbench

//   In-order issue controller for the 4-stage pipelined ALU (regbank 16x16, mem 256x16).

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_issue_fifo.sv | 60 ++++++
 rtl/alu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller.
package alu_pkg;

    localparam int unsigned REG_W  = 4;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned FUNC_W = 4;

    // Function codes run from ADD (0) up to 11; anything at or above NUM_FUNC is illegal.
    localparam logic [FUNC_W-1:0] FUNC_ADD = 4'd0;
    localparam logic [FUNC_W-1:0] NUM_FUNC = 4'd12;

    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    function automatic logic func_legal(input logic [FUNC_W-1:0] f);
        return f < NUM_FUNC;
    endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous instruction FIFO; head is visible combinationally, no bypass.
module alu_issue_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   flush_i,
    input  logic   push_i,
    input  instr_t data_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output instr_t head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    instr_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push_ok, pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers; flush empties the FIFO on the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
            if (pop_ok)  rptr_q <= rptr_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are don't-care while the slot is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// In-order issue controller: FIFO, RAW scoreboard, illegal-func drop, stall counter.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WB_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              flush,
    output logic              iss_valid,
    output logic [REG_W-1:0]  iss_rs1,
    output logic [REG_W-1:0]  iss_rs2,
    output logic [REG_W-1:0]  iss_rd,
    output logic [FUNC_W-1:0] iss_func,
    output logic [ADDR_W-1:0] iss_addr,
    output logic              illegal,
    output logic [15:0]       stall_cnt,
    output logic              busy
);

    instr_t            in_instr, head;
    logic              full, empty, push, pop;
    logic              head_valid, legal, hazard;
    logic              do_issue, do_drop, do_stall;

    instr_t            iss_q;
    logic              iss_valid_q, illegal_q;
    logic [15:0]       stall_cnt_q;

    // sb[0] tracks the instruction currently on the issue outputs, so an rd stays
    // pending for WB_LAT cycles starting with its issue cycle.
    logic [WB_LAT-1:0] sb_v_q;
    logic [REG_W-1:0]  sb_rd_q [WB_LAT];

    assign in_instr = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
    assign in_ready = !full;
    assign push     = in_valid && !full && !flush;
    assign pop      = do_issue || do_drop;

    alu_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (in_instr),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    // Hazard detection and issue/drop/stall decision for the FIFO head.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < WB_LAT; i++) begin
            if (sb_v_q[i] && (sb_rd_q[i] == head.rs1 || sb_rd_q[i] == head.rs2)) begin
                hazard = 1'b1;
            end
        end
        head_valid = !empty && !flush;
        legal      = func_legal(head.func);
        do_issue   = head_valid && legal && !hazard;
        do_drop    = head_valid && !legal;
        do_stall   = head_valid && legal && hazard;
    end

    // Scoreboard shift register of issued destination registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_v_q <= '0;
            for (int unsigned i = 0; i < WB_LAT; i++) sb_rd_q[i] <= '0;
        end else begin
            sb_v_q[0]  <= do_issue;
            sb_rd_q[0] <= do_issue ? head.rd : '0;
            for (int unsigned i = 1; i < WB_LAT; i++) begin
                sb_v_q[i]  <= sb_v_q[i-1];
                sb_rd_q[i] <= sb_rd_q[i-1];
            end
        end
    end

    // Registered issue outputs, illegal pulse and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_q       <= '0;
            iss_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            iss_valid_q <= do_issue;
            iss_q       <= do_issue ? head : '0;
            illegal_q   <= do_drop;
            if (do_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_rs1   = iss_q.rs1;
    assign iss_rs2   = iss_q.rs2;
    assign iss_rd    = iss_q.rd;
    assign iss_func  = iss_q.func;
    assign iss_addr  = iss_q.addr;
    assign illegal   = illegal_q;
    assign stall_cnt = stall_cnt_q;
    assign busy      = !empty || (|sb_v_q);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table plus full/flush sequences.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } ins_t;

    typedef struct {
        ins_t a;
        ins_t b;
        int   exp_ill;
        int   exp_gap;
        int   exp_stall;
    } vec_t;

    typedef struct {
        int   cyc;
        ins_t ins;
    } iss_rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_func = '0;
    logic [7:0]  in_addr = '0;
    logic        flush = 1'b0;
    logic        iss_valid;
    logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0]  iss_addr;
    logic        illegal;
    logic [15:0] stall_cnt;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int idle_nz = 0;

    iss_rec_t iss_log[$];
    int       ill_log[$];

    alu_issue_ctrl #(
        .DEPTH  (4),
        .WB_LAT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_func   (in_func),
        .in_addr   (in_addr),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_func  (iss_func),
        .iss_addr  (iss_addr),
        .illegal   (illegal),
        .stall_cnt (stall_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log issue strobes and illegal pulses mid-cycle.
    always @(negedge clk) begin : monitor
        iss_rec_t r;
        if (!rst) begin
            if (iss_valid) begin
                r.cyc = cyc;
                r.ins = {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr};
                iss_log.push_back(r);
            end else if ({iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr} != 24'd0) begin
                idle_nz++;
            end
            if (illegal) ill_log.push_back(cyc);
        end
    end

    function automatic ins_t mk(input int rs1, input int rs2, input int rd, input int func,
                                input int addr);
        ins_t r;
        r.rs1  = 4'(rs1);
        r.rs2  = 4'(rs2);
        r.rd   = 4'(rd);
        r.func = 4'(func);
        r.addr = 8'(addr);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        iss_log.delete();
        ill_log.delete();
    endtask

    task automatic push(input ins_t i, output int waits);
        logic rdy;
        waits    = 0;
        in_valid = 1'b1;
        {in_rs1, in_rs2, in_rd, in_func, in_addr} = i;
        while (1) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waits++;
            if (waits > 50) begin
                chk("push_timeout", 32'd1, 32'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vecs[9];

    initial begin : main
        int w, k, a_cyc;
        ins_t seq[6];
        ins_t p, q, r, s, t;

        vecs[0] = '{a: mk(3,5,10,0,125),  b: mk(7,3,13,11,127), exp_ill: 0, exp_gap: 1, exp_stall: 0};
        vecs[1] = '{a: mk(3,5,10,0,125),  b: mk(10,5,14,1,128), exp_ill: 0, exp_gap: 4, exp_stall: 3};
        vecs[2] = '{a: mk(3,5,10,0,125),  b: mk(5,10,14,1,128), exp_ill: 0, exp_gap: 4, exp_stall: 3};
        vecs[3] = '{a: mk(3,5,10,0,125),  b: mk(1,2,10,2,129),  exp_ill: 0, exp_gap: 1, exp_stall: 0};
        vecs[4] = '{a: mk(3,5,10,0,125),  b: mk(10,10,6,3,200), exp_ill: 0, exp_gap: 4, exp_stall: 3};
        vecs[5] = '{a: mk(1,1,10,13,0),   b: mk(1,2,3,0,130),   exp_ill: 1, exp_gap: 1, exp_stall: 0};
        vecs[6] = '{a: mk(0,0,10,12,0),   b: mk(10,10,4,5,7),   exp_ill: 1, exp_gap: 1, exp_stall: 0};
        vecs[7] = '{a: mk(2,2,9,11,9),    b: mk(9,1,2,3,4),     exp_ill: 0, exp_gap: 4, exp_stall: 3};
        vecs[8] = '{a: mk(10,10,10,15,255), b: mk(10,4,5,6,8),  exp_ill: 1, exp_gap: 1, exp_stall: 0};

        // Reset state
        do_reset();
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_illegal",   illegal,   0);

        // Two-instruction vectors
        foreach (vecs[v]) begin
            do_reset();
            push(vecs[v].a, w);
            push(vecs[v].b, w);
            k = 0;
            while (iss_log.size() + ill_log.size() < 2 && k < 30) begin
                tick(1);
                k++;
            end
            chk($sformatf("v%0d_events", v), iss_log.size() + ill_log.size(), 2);
            chk($sformatf("v%0d_n_iss", v), iss_log.size(), 2 - vecs[v].exp_ill);
            chk($sformatf("v%0d_n_ill", v), ill_log.size(), vecs[v].exp_ill);
            if (iss_log.size() > 0) begin
                chk($sformatf("v%0d_b_fields", v), iss_log[$].ins, vecs[v].b);
                a_cyc = -100;
                if (vecs[v].exp_ill != 0 && ill_log.size() > 0) a_cyc = ill_log[0];
                if (vecs[v].exp_ill == 0 && iss_log.size() > 1) begin
                    chk($sformatf("v%0d_a_fields", v), iss_log[0].ins, vecs[v].a);
                    a_cyc = iss_log[0].cyc;
                end
                chk($sformatf("v%0d_gap", v), iss_log[$].cyc - a_cyc, vecs[v].exp_gap);
            end
            chk($sformatf("v%0d_stall", v), stall_cnt, vecs[v].exp_stall);
            tick(6);
            chk($sformatf("v%0d_idle_busy", v), busy, 0);
        end

        // FIFO full: B blocked behind A, C..F queue up, F must wait for B to pop
        do_reset();
        seq[0] = mk(3,5,10,0,125);
        seq[1] = mk(10,5,11,1,1);
        seq[2] = mk(1,2,3,2,2);
        seq[3] = mk(4,4,4,3,3);
        seq[4] = mk(5,6,7,4,4);
        seq[5] = mk(8,9,12,5,5);
        for (int i = 0; i < 5; i++) push(seq[i], w);
        chk("full_in_ready", in_ready, 0);
        chk("full_busy", busy, 1);
        push(seq[5], w);
        chk("full_f_waits", w, 1);
        k = 0;
        while (iss_log.size() < 6 && k < 30) begin
            tick(1);
            k++;
        end
        chk("full_n_iss", iss_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < iss_log.size()) chk($sformatf("full_order%0d", i), iss_log[i].ins, seq[i]);
        end
        chk("full_stall", stall_cnt, 3);

        // Flush: R,S,T queued behind Q's hazard; scoreboard keeps busy high until it drains
        do_reset();
        p = mk(0,0,10,0,10);
        q = mk(10,1,11,1,11);
        r = mk(11,2,12,2,12);
        s = mk(3,4,13,3,13);
        t = mk(5,6,14,4,14);
        push(p, w);
        push(q, w);
        push(r, w);
        push(s, w);
        push(t, w);
        tick(1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_busy_held", busy, 1);
        chk("flush_in_ready", in_ready, 1);
        k = 0;
        while (busy && k < 10) begin
            tick(1);
            k++;
        end
        chk("flush_drain_le_wblat", (k >= 1 && k <= 3), 1);
        tick(8);
        chk("flush_n_iss", iss_log.size(), 2);
        chk("flush_busy_end", busy, 0);
        chk("flush_stall_kept", stall_cnt, 3);
        chk("flush_n_ill", ill_log.size(), 0);

        chk("idle_fields_zero", idle_nz, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
